// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc main controller: trigger codes, sequencer states,
// the CSR configuration word and the per-layer snapshot taken at trigger time.
package qracc_pkg;

  localparam int unsigned QRACC_COORD_W = 16;

  typedef logic [2:0] qracc_trigger_t;

  localparam qracc_trigger_t TRIGGER_COMPUTE = 3'd1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ISSUE = 4'd1,
    DRAIN = 4'd2,
    DONE  = 4'd3
  } seq_state_t;

  typedef struct packed {
    logic [QRACC_COORD_W-1:0] output_fmap_dimx;
    logic [QRACC_COORD_W-1:0] output_fmap_dimy;
    logic [QRACC_COORD_W-1:0] stride_x;
    logic [QRACC_COORD_W-1:0] stride_y;
    logic [QRACC_COORD_W-1:0] padding;
  } qracc_config_t;

  typedef struct packed {
    logic [QRACC_COORD_W-1:0] dimx;
    logic [QRACC_COORD_W-1:0] dimy;
    logic [QRACC_COORD_W-1:0] stride_x;
    logic [QRACC_COORD_W-1:0] stride_y;
    logic [QRACC_COORD_W-1:0] padding;
  } seq_snapshot_t;

  function automatic seq_snapshot_t snapshot_of(input qracc_config_t cfg);
    seq_snapshot_t s;
    s.dimx     = cfg.output_fmap_dimx;
    s.dimy     = cfg.output_fmap_dimy;
    s.stride_x = cfg.stride_x;
    s.stride_y = cfg.stride_y;
    s.padding  = cfg.padding;
    return s;
  endfunction

endpackage

// File: rtl/qracc_ofmap_walker.sv
// Raster walker over the output feature map: ox/oy counters, input-window
// origin accumulators (no multipliers), flat address and last-window flag.
module qracc_ofmap_walker
  import qracc_pkg::*;
#(
  parameter int unsigned CoordWidth = 16,
  parameter int unsigned AddrWidth  = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        clear,
  input  logic                        load,
  input  seq_snapshot_t               cfg,
  input  logic                        step,
  output logic signed [CoordWidth:0]  win_x,
  output logic signed [CoordWidth:0]  win_y,
  output logic [AddrWidth-1:0]        addr,
  output logic                        last
);

  seq_snapshot_t         snap;
  logic [CoordWidth-1:0] ox;
  logic [CoordWidth-1:0] oy;
  logic [CoordWidth-1:0] ox_next;
  logic [CoordWidth-1:0] oy_next;
  logic [CoordWidth-1:0] dimx_m1;
  logic [CoordWidth-1:0] dimy_m1;
  logic [CoordWidth:0]   stride_x_ext;
  logic [CoordWidth:0]   stride_y_ext;
  logic [CoordWidth:0]   pad_snap_ext;
  logic [CoordWidth:0]   pad_cfg_ext;
  logic                  row_end;
  logic                  last_next;
  logic                  last_init;

  always_comb begin
    dimx_m1      = CoordWidth'(snap.dimx) - CoordWidth'(1);
    dimy_m1      = CoordWidth'(snap.dimy) - CoordWidth'(1);
    row_end      = (ox == dimx_m1);
    ox_next      = row_end ? '0 : ox + CoordWidth'(1);
    oy_next      = row_end ? oy + CoordWidth'(1) : oy;
    // After the final window oy runs past dimy-1, so last drops by itself.
    last_next    = (ox_next == dimx_m1) && (oy_next == dimy_m1);
    last_init    = (CoordWidth'(cfg.dimx) == CoordWidth'(1)) &&
                   (CoordWidth'(cfg.dimy) == CoordWidth'(1));
    stride_x_ext = {1'b0, CoordWidth'(snap.stride_x)};
    stride_y_ext = {1'b0, CoordWidth'(snap.stride_y)};
    pad_snap_ext = {1'b0, CoordWidth'(snap.padding)};
    pad_cfg_ext  = {1'b0, CoordWidth'(cfg.padding)};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      snap  <= '0;
      ox    <= '0;
      oy    <= '0;
      win_x <= '0;
      win_y <= '0;
      addr  <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      snap  <= '0;
      ox    <= '0;
      oy    <= '0;
      win_x <= '0;
      win_y <= '0;
      addr  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      snap  <= cfg;
      ox    <= '0;
      oy    <= '0;
      win_x <= -pad_cfg_ext;
      win_y <= -pad_cfg_ext;
      addr  <= '0;
      last  <= last_init;
    end else if (step) begin
      ox   <= ox_next;
      oy   <= oy_next;
      addr <= addr + AddrWidth'(1);
      last <= last_next;
      if (row_end) begin
        win_x <= -pad_snap_ext;
        win_y <= win_y + stride_y_ext;
      end else begin
        win_x <= win_x + stride_x_ext;
      end
    end
  end

endmodule

// File: rtl/qracc_window_sequencer.sv
// QRAcc main controller: issues one input-window request per output pixel and
// tracks completions. Optional stall counter enabled by QRACC_SEQ_PERF_EN.
module qracc_window_sequencer
  import qracc_pkg::*;
#(
  parameter int unsigned CoordWidth     = 16,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  qracc_config_t               cfg_i,
  input  qracc_trigger_t              trigger_i,
  input  logic                        clear_i,
  output logic                        busy_o,
  output logic [3:0]                  state_o,
  output logic                        win_valid_o,
  input  logic                        win_ready_i,
  output logic signed [CoordWidth:0]  win_x_o,
  output logic signed [CoordWidth:0]  win_y_o,
  output logic [AddrWidth-1:0]        ofmap_addr_o,
  output logic                        win_last_o,
  input  logic                        win_done_i,
  output logic                        layer_done_o,
  output logic [31:0]                 perf_stall_cycles_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  seq_state_t    state;
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] count_next;
  logic          accept;
  logic          done_ok;
  logic          trig_ok;
  logic          dims_zero;
  logic          walker_load;
  logic          walker_step;

  always_comb begin
    accept      = win_valid_o && win_ready_i;
    done_ok     = win_done_i && (outstanding != '0);
    trig_ok     = (state == IDLE) && (trigger_i == TRIGGER_COMPUTE);
    dims_zero   = (cfg_i.output_fmap_dimx == '0) || (cfg_i.output_fmap_dimy == '0);
    walker_load = trig_ok && !clear_i;
    walker_step = accept && !clear_i;
    count_next  = outstanding;
    case ({accept, done_ok})
      2'b10:   count_next = outstanding + CntW'(1);
      2'b01:   count_next = outstanding - CntW'(1);
      default: count_next = outstanding;
    endcase
  end

  qracc_ofmap_walker #(
    .CoordWidth (CoordWidth),
    .AddrWidth  (AddrWidth)
  ) u_walker (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear_i),
    .load  (walker_load),
    .cfg   (snapshot_of(cfg_i)),
    .step  (walker_step),
    .win_x (win_x_o),
    .win_y (win_y_o),
    .addr  (ofmap_addr_o),
    .last  (win_last_o)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      win_valid_o  <= 1'b0;
      layer_done_o <= 1'b0;
      outstanding  <= '0;
    end else if (clear_i) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      win_valid_o  <= 1'b0;
      layer_done_o <= 1'b0;
      outstanding  <= '0;
    end else begin
      outstanding  <= count_next;
      layer_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_ok) begin
            busy_o <= 1'b1;
            if (dims_zero) begin
              state        <= DONE;
              layer_done_o <= 1'b1;
            end else begin
              state       <= ISSUE;
              win_valid_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Valid is registered from the post-edge count, so it is low
          // exactly while the outstanding limit is reached.
          if (accept && win_last_o) begin
            state       <= DRAIN;
            win_valid_o <= 1'b0;
          end else begin
            win_valid_o <= (count_next < MaxCnt);
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state        <= DONE;
            layer_done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          win_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

`ifdef QRACC_SEQ_PERF_EN
  logic [31:0] perf;

  // In ISSUE the request is either held by backpressure or blocked by the
  // outstanding limit whenever no accept happens.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf <= '0;
    end else if (clear_i || trig_ok) begin
      perf <= '0;
    end else if ((state == ISSUE) && !accept && (perf != '1)) begin
      perf <= perf + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf;
`else
  assign perf_stall_cycles_o = '0;
`endif

endmodule
